// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage valid/ctrl/data pipeline register with
// stall, flush and masked bubble; PIPE_REG_PERF_EN adds event counters.
module pipe_stage_reg #(
   parameter int                 DATA_W    = 32,
   parameter int                 CTRL_W    = 16,
   parameter int                 DEPTH     = 1,
   parameter logic [CTRL_W-1:0]  KILL_MASK = {CTRL_W{1'b1}},
   parameter int                 CNT_W     = 16
) (
   input  logic              Clk,
   input  logic              Clrn,
   input  logic              stall,
   input  logic              flush,
   input  logic              bubble,
   input  logic              in_valid,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0]  cnt_stall,
   output logic [CNT_W-1:0]  cnt_flush,
   output logic [CNT_W-1:0]  cnt_bubble
`endif
);

   if (DEPTH < 1 || DEPTH > 8 || CNT_W < 1) begin : g_bad_param
      $error("pipe_stage_reg: DEPTH must be 1..8 and CNT_W >= 1");
   end

   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

   // next stage contents: flush > stall > bubble > normal shift
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = '0;
         ctrl_d  = '0;
         data_d  = '0;
      end else if (!stall) begin
         valid_d[0] = bubble ? 1'b0 : in_valid;
         ctrl_d[0]  = bubble ? (in_ctrl & ~KILL_MASK) : in_ctrl;
         data_d[0]  = in_data;
         for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k-1];
            ctrl_d[k]  = ctrl_q[k-1];
            data_d[k]  = data_q[k-1];
         end
      end
   end

   // stage registers update on the falling edge, cleared asynchronously
   always_ff @(negedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         valid_q <= '0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_ctrl  = ctrl_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_REG_PERF_EN
   logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
   logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;
   logic [CNT_W-1:0] cnt_bubble_q, cnt_bubble_d;

   // saturating count of the event that wins priority this edge
   always_comb begin
      cnt_stall_d  = cnt_stall_q;
      cnt_flush_d  = cnt_flush_q;
      cnt_bubble_d = cnt_bubble_q;
      if (flush) begin
         if (!(&cnt_flush_q)) cnt_flush_d = cnt_flush_q + 1'b1;
      end else if (stall) begin
         if (!(&cnt_stall_q)) cnt_stall_d = cnt_stall_q + 1'b1;
      end else if (bubble) begin
         if (!(&cnt_bubble_q)) cnt_bubble_d = cnt_bubble_q + 1'b1;
      end
   end

   // counter registers, cleared only by reset
   always_ff @(negedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         cnt_stall_q  <= '0;
         cnt_flush_q  <= '0;
         cnt_bubble_q <= '0;
      end else begin
         cnt_stall_q  <= cnt_stall_d;
         cnt_flush_q  <= cnt_flush_d;
         cnt_bubble_q <= cnt_bubble_d;
      end
   end

   assign cnt_stall  = cnt_stall_q;
   assign cnt_flush  = cnt_flush_q;
   assign cnt_bubble = cnt_bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: DEPTH=3 and DEPTH=1 instances checked against a
// history-queue model plus hand-computed expectations.
module tb_pipe_stage_reg;

   logic        Clk = 1'b0;
   logic        Clrn = 1'b1;
   logic        stall = 1'b0, flush = 1'b0, bubble = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_ctrl = '0;
   logic [31:0] in_data = '0;

   logic        o3v, o1v;
   logic [15:0] o3c, o1c;
   logic [31:0] o3d, o1d;
`ifdef PIPE_REG_PERF_EN
   logic [3:0]  c3s, c3f, c3b, c1s, c1f, c1b;
`endif

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   typedef logic [48:0] ent_t;
   ent_t hist[$];
   int m_st = 0, m_fl = 0, m_bu = 0;

   pipe_stage_reg #(
      .DATA_W(32), .CTRL_W(16), .DEPTH(3),
      .KILL_MASK(16'h00F0), .CNT_W(4)
   ) u3 (
      .Clk(Clk), .Clrn(Clrn), .stall(stall), .flush(flush),
      .bubble(bubble), .in_valid(in_valid), .in_ctrl(in_ctrl),
      .in_data(in_data), .out_valid(o3v), .out_ctrl(o3c),
      .out_data(o3d)
`ifdef PIPE_REG_PERF_EN
      , .cnt_stall(c3s), .cnt_flush(c3f), .cnt_bubble(c3b)
`endif
   );

   pipe_stage_reg #(
      .DATA_W(32), .CTRL_W(16), .DEPTH(1),
      .KILL_MASK(16'h00F0), .CNT_W(4)
   ) u1 (
      .Clk(Clk), .Clrn(Clrn), .stall(stall), .flush(flush),
      .bubble(bubble), .in_valid(in_valid), .in_ctrl(in_ctrl),
      .in_data(in_data), .out_valid(o1v), .out_ctrl(o1c),
      .out_data(o1d)
`ifdef PIPE_REG_PERF_EN
      , .cnt_stall(c1s), .cnt_flush(c1f), .cnt_bubble(c1b)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(int v);
      return (v < 15) ? v + 1 : 15;
   endfunction

   // model: every advancing edge appends one entry; a depth-D stage
   // shows the entry appended D-1 advancing edges ago; flush and reset
   // replace history with zero entries
   always @(negedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         hist.delete();
         repeat (8) hist.push_back('0);
         m_st = 0; m_fl = 0; m_bu = 0;
      end else if (flush) begin
         repeat (8) hist.push_back('0);
         m_fl = sat(m_fl);
      end else if (stall) begin
         m_st = sat(m_st);
      end else if (bubble) begin
         hist.push_back({1'b0, in_ctrl & ~16'h00F0, in_data});
         m_bu = sat(m_bu);
      end else begin
         hist.push_back({in_valid, in_ctrl, in_data});
      end
      while (hist.size() > 16) void'(hist.pop_front());
   end

   function automatic ent_t exp_out(int d);
      return hist[hist.size() - d];
   endfunction

   // compare both instances against the model every rising edge
   always @(posedge Clk) begin
      if (started) begin
         chk("cmp_d3", {15'd0, o3v, o3c, o3d}, {15'd0, exp_out(3)});
         chk("cmp_d1", {15'd0, o1v, o1c, o1d}, {15'd0, exp_out(1)});
`ifdef PIPE_REG_PERF_EN
         chk("cmp_cnt3", {52'd0, c3s, c3f, c3b},
             {52'd0, m_st[3:0], m_fl[3:0], m_bu[3:0]});
         chk("cmp_cnt1", {52'd0, c1s, c1f, c1b},
             {52'd0, m_st[3:0], m_fl[3:0], m_bu[3:0]});
`endif
      end
   end

   task automatic cyc(logic v, logic [15:0] c, logic [31:0] d,
                      logic s, logic f, logic b);
      in_valid = v; in_ctrl = c; in_data = d;
      stall = s; flush = f; bubble = b;
      @(negedge Clk);
      #1;
   endtask

   initial begin
      in_valid = 1'b1; in_ctrl = 16'hFFFF; in_data = 32'hDEADBEEF;
      #2 Clrn = 1'b0;
      #1;
      chk("rst_imm3", {15'd0, o3v, o3c, o3d}, 64'd0);
      chk("rst_imm1", {15'd0, o1v, o1c, o1d}, 64'd0);
      cyc(1'b1, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      started = 1'b1;
      cyc(1'b1, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      chk("rst_hold3", {15'd0, o3v, o3c, o3d}, 64'd0);
      Clrn = 1'b1;

      cyc(1'b1, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      chk("rel_d1", {15'd0, o1v, o1c, o1d}, {15'd0, 1'b1, 48'hFFFF_DEADBEEF});
      chk("rel_d3_e1", {63'd0, o3v}, 64'd0);
      cyc(1'b1, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      chk("rel_d3", {15'd0, o3v, o3c, o3d}, {15'd0, 1'b1, 48'hFFFF_DEADBEEF});

      for (int i = 1; i <= 7; i++) begin
         cyc(1'b1, 16'h0100 | 16'(i), 32'(i), 1'b0, 1'b0, 1'b0);
         chk("str_d1", {32'd0, o1d}, 64'(i));
         if (i >= 3) begin
            chk("str_d3", {31'd0, o3v, o3d}, {31'd0, 1'b1, 32'(i - 2)});
         end
      end

      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 16'h0BAD, $urandom, 1'b1, 1'b0, 1'b0);
         chk("stall_d3", {32'd0, o3d}, 64'h5);
         chk("stall_d1", {32'd0, o1d}, 64'h7);
      end
`ifdef PIPE_REG_PERF_EN
      chk("stall_cnt", {60'd0, c3s}, 64'd3);
`endif

      cyc(1'b1, 16'h12FF, 32'h40, 1'b0, 1'b0, 1'b1);
      chk("bub_d1", {15'd0, o1v, o1c, o1d}, {15'd0, 1'b0, 48'h120F_00000040});
      cyc(1'b1, 16'h0001, 32'h50, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'h0002, 32'h60, 1'b0, 1'b0, 1'b0);
      chk("bub_d3", {15'd0, o3v, o3c, o3d}, {15'd0, 1'b0, 48'h120F_00000040});

      cyc(1'b1, 16'h0003, 32'h70, 1'b0, 1'b0, 1'b0);
      chk("full_d3", {31'd0, o3v, o3d}, {31'd0, 1'b1, 32'h50});
      cyc(1'b1, 16'h0005, 32'h80, 1'b1, 1'b1, 1'b1);
      chk("fsb_d3", {15'd0, o3v, o3c, o3d}, 64'd0);
      chk("fsb_d1", {15'd0, o1v, o1c, o1d}, 64'd0);
`ifdef PIPE_REG_PERF_EN
      chk("fsb_cnt", {52'd0, c3s, c3f, c3b}, {52'd0, 4'd3, 4'd1, 4'd1});
`endif

      for (int n = 0; n < 400; n++) begin
         cyc(1'($urandom), 16'($urandom), $urandom,
             ($urandom_range(7) == 0), ($urandom_range(15) == 0),
             ($urandom_range(7) == 0));
      end

      cyc(1'b1, 16'hAAAA, 32'h1234, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hAAAA, 32'h1234, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hAAAA, 32'h1234, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_d3", {15'd0, o3v, o3c, o3d}, {15'd0, 1'b1, 48'hAAAA_00001234});
      Clrn = 1'b0;
      #1;
      chk("mid_rst_d3", {15'd0, o3v, o3c, o3d}, 64'd0);
      chk("mid_rst_d1", {15'd0, o1v, o1c, o1d}, 64'd0);
`ifdef PIPE_REG_PERF_EN
      chk("mid_rst_cnt", {52'd0, c3s, c3f, c3b}, 64'd0);
`endif
      #1 Clrn = 1'b1;
      cyc(1'b1, 16'h0007, 32'h99, 1'b0, 1'b0, 1'b0);
      chk("post_rst_d1", {15'd0, o1v, o1c, o1d}, {15'd0, 1'b1, 48'h0007_00000099});

      for (int n = 0; n < 20; n++) begin
         cyc(1'b0, 16'hFFFF, $urandom, 1'b0, 1'b0, 1'b1);
      end
`ifdef PIPE_REG_PERF_EN
      chk("sat_bub3", {60'd0, c3b}, 64'hF);
      chk("sat_bub1", {60'd0, c1b}, 64'hF);
`endif
      cyc(1'b0, 16'hFFFF, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("sat_d1", {15'd0, o1v, o1c, o1d}, {15'd0, 1'b0, 48'hFF0F_00000000});
`ifdef PIPE_REG_PERF_EN
      chk("sat_hold", {60'd0, c3b}, 64'hF);
`endif

      started = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised multi-stage pipeline register, the generalised successor of the fixed ID/EX stage register. Carries a configurable control word and data word through DEPTH cascaded stages, each with a valid bit. Supports hold (stall), full flush (control hazard) and bubble insertion with a per-bit kill mask (load-use hazard). Instantiated between any two pipeline stages of the CPU; optional hazard event counters feed performance debug.

## Interface
- DATA_W, 32: width of the data payload (PC4, bus values, immediates, register numbers, concatenated by the instantiating stage)
- CTRL_W, 16: width of the control payload
- DEPTH, 1: number of cascaded register stages; legal range 1..8
- KILL_MASK, {CTRL_W{1'b1}}: control bits forced to 0 on bubble; bits at 0 pass through unchanged
- CNT_W, 16: event counter width; used only with PIPE_REG_PERF_EN

Ports:
- Clk  in  1  clock; all state updates on the falling edge
- Clrn  in  1  reset; asynchronous, active-low
- stall  in  1  hold all stages this edge
- flush  in  1  clear all stages this edge
- bubble  in  1  insert a bubble into stage 0 this edge
- in_valid  in  1  upstream slot holds a real instruction
- in_ctrl  in  CTRL_W  upstream control word
- in_data  in  DATA_W  upstream data word
- out_valid  out  1  valid bit of stage DEPTH-1
- out_ctrl  out  CTRL_W  control word of stage DEPTH-1
- out_data  out  DATA_W  data word of stage DEPTH-1
- cnt_stall, cnt_flush, cnt_bubble  out  CNT_W each  event counters (present only with PIPE_REG_PERF_EN)

## Operation
- Per-stage state: valid, ctrl, data. Stage 0 loads from inputs; stage k loads from stage k-1.
- Priority on each falling edge, highest first: reset, flush, stall, bubble, normal.
- Reset (Clrn=0, asynchronous): all valid, ctrl and data of every stage = 0; counters = 0. Held while Clrn=0.
- flush=1: every stage valid=0, ctrl=0, data=0. stall and bubble ignored that edge.
- stall=1 (no flush): every stage holds its contents; bubble ignored; upstream must also hold its inputs.
- bubble=1 (no flush, no stall): stage 0 gets valid=0, ctrl=in_ctrl & ~KILL_MASK, data=in_data; stages 1..DEPTH-1 shift normally.
- Normal: stage 0 gets {in_valid, in_ctrl, in_data}; stages 1..DEPTH-1 shift.
- in_valid=0 with no event: stage 0 loads in_valid=0 but ctrl and data as given (no masking; the upstream stage is responsible for zeroing).
- Outputs are direct register outputs of the last stage; no combinational path from any input to any output.
- DEPTH outside 1..8: elaboration error.

## Timing
- Latency: an input sampled on falling edge n appears at the outputs after edge n+DEPTH-1 (DEPTH=1: visible right after edge n).
- Each stall edge adds one cycle of latency to every in-flight stage.
- Flush takes effect on the edge it is sampled; output is all-zero immediately after that edge.
- Reset asserted mid-stream clears all outputs asynchronously, without waiting for an edge; the first edge after release loads normally.
- Reset release must not coincide with a falling edge (integration requirement).

## Configuration
- PIPE_REG_PERF_EN defined: three saturating CNT_W counters, incremented once per falling edge on which the event wins priority (cnt_flush on flush; cnt_stall on stall without flush; cnt_bubble on bubble without flush/stall). Counters stick at all-ones; cleared only by reset.
- Not defined: counter ports and logic absent; datapath behaviour identical.

## Test plan
- Reset: drive in_ctrl=16'hFFFF, in_data=32'hDEADBEEF, in_valid=1, Clrn=0 -> out_valid=0, out_ctrl=0, out_data=0 immediately, held across edges; release -> values appear after DEPTH edges.
- DEPTH=3 streaming: inputs 1,2,3,4 on successive edges -> out_data 1 after edge 3, then 2,3,4 on following edges, out_valid=1.
- Bubble, KILL_MASK=16'h00F0, in_ctrl=16'h12FF, in_data=32'h40 -> stage output valid=0, ctrl=16'h120F, data=32'h40.
- Simultaneous flush+stall+bubble with DEPTH=2 full of valid data -> all outputs 0 after that edge; with PERF: cnt_flush=1, cnt_stall=0, cnt_bubble=0.
- Stall for 3 edges with out_data=32'h5 -> out_data stays 32'h5, in_data changes ignored; with PERF cnt_stall=3.
- PERF saturation, CNT_W=4: 20 consecutive bubble edges -> cnt_bubble=4'hF, remains 4'hF.
